// File: rtl/if_redirect_unit_pkg.sv
// rtl/if_redirect_unit_pkg.sv - shared fetch/redirect types, constants and target alignment helper
package if_redirect_unit_pkg;

    typedef enum logic [1:0] {
        PC_SEQ    = 2'b00,
        PC_JALR   = 2'b01,
        PC_BRANCH = 2'b10,
        PC_JAL    = 2'b11
    } pc_sel_t;

    typedef enum logic [1:0] {
        S_REQ  = 2'b00,
        S_WAIT = 2'b01,
        S_HOLD = 2'b10
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OP_IMM = 7'b0010011;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/if_redirect_unit_if_de_reg.sv
// rtl/if_redirect_unit_if_de_reg.sv - IF/DE pipeline register with clear/hold/load and NOP bubbles
module if_de_reg #(
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        hold,
    input  logic        load,
    input  logic [31:0] pc_in,
    input  logic [31:0] ir_in,
    output logic [31:0] de_pc,
    output logic [31:0] de_ir,
    output logic        de_valid
);

    // Priority: clear > hold > load > bubble; de_pc is left alone when the slot empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            de_pc    <= 32'h0000_0000;
            de_ir    <= NOP_INSTR;
            de_valid <= 1'b0;
        end else if (clear) begin
            de_ir    <= NOP_INSTR;
            de_valid <= 1'b0;
        end else if (!hold) begin
            if (load) begin
                de_pc    <= pc_in;
                de_ir    <= ir_in;
                de_valid <= 1'b1;
            end else begin
                de_ir    <= NOP_INSTR;
                de_valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/if_redirect_unit.sv
// rtl/if_redirect_unit.sv - PC register, single-outstanding imem fetch FSM and redirect/stall handling
module if_redirect_unit #(
    parameter logic [31:0] RESET_PC  = if_redirect_unit_pkg::RESET_PC,
    parameter logic [31:0] NOP_INSTR = if_redirect_unit_pkg::NOP_INSTR
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] jalr_pc,
    input  logic [31:0] branch_pc,
    input  logic [31:0] jal_pc,
    input  logic        flush,
    input  logic        load_use_haz,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] de_pc,
    output logic [31:0] de_ir,
    output logic        de_valid,
    output logic        misalign_err
);
    import if_redirect_unit_pkg::*;

    fetch_state_t state, state_nx;
    logic [31:0]  pc, pc_nx;
    logic [31:0]  hold_ir, hold_nx;
    logic [31:0]  raw_target, target, de_src;
    logic         discard, discard_nx;
    logic         redirect, accept, can_load, de_load;

    always_comb begin
        case (pc_sel_t'(pc_sel))
            PC_JALR:   raw_target = jalr_pc & ~32'h0000_0001;
            PC_BRANCH: raw_target = branch_pc;
            PC_JAL:    raw_target = jal_pc;
            default:   raw_target = pc;
        endcase
    end

    assign target    = word_align(raw_target);
    assign redirect  = (pc_sel != PC_SEQ);
    assign imem_req  = RST_N && (state == S_REQ);
    assign imem_addr = pc;
    assign accept    = imem_req && imem_ready;
    // A bare flush empties IF/DE without consuming the fetched word, so it blocks loading too.
    assign can_load  = !load_use_haz && !redirect && !flush;

    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        discard_nx = discard;
        hold_nx    = hold_ir;
        de_load    = 1'b0;
        de_src     = imem_rdata;
        case (state)
            S_REQ: begin
                if (accept) state_nx = S_WAIT;
                if (redirect) begin
                    pc_nx      = target;
                    discard_nx = accept;
                end
            end
            S_WAIT: begin
                if (imem_rvalid) begin
                    state_nx   = S_REQ;
                    discard_nx = 1'b0;
                    if (redirect) begin
                        pc_nx = target;
                    end else if (!discard) begin
                        if (can_load) begin
                            de_load = 1'b1;
                            pc_nx   = pc + 32'd4;
                        end else begin
                            hold_nx  = imem_rdata;
                            state_nx = S_HOLD;
                        end
                    end
                end else if (redirect) begin
                    pc_nx      = target;
                    discard_nx = 1'b1;
                end
            end
            S_HOLD: begin
                de_src = hold_ir;
                if (redirect) begin
                    pc_nx    = target;
                    state_nx = S_REQ;
                end else if (can_load) begin
                    de_load  = 1'b1;
                    pc_nx    = pc + 32'd4;
                    state_nx = S_REQ;
                end
            end
            default: state_nx = S_REQ;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state        <= S_REQ;
            pc           <= RESET_PC;
            discard      <= 1'b0;
            hold_ir      <= NOP_INSTR;
            misalign_err <= 1'b0;
        end else begin
            state        <= state_nx;
            pc           <= pc_nx;
            discard      <= discard_nx;
            hold_ir      <= hold_nx;
            misalign_err <= misalign_err | (redirect & raw_target[1]);
        end
    end

    if_de_reg #(
        .NOP_INSTR (NOP_INSTR)
    ) u_if_de_reg (
        .clk      (CLK),
        .rst_n    (RST_N),
        .clear    (redirect | flush),
        .hold     (load_use_haz),
        .load     (de_load),
        .pc_in    (pc),
        .ir_in    (de_src),
        .de_pc    (de_pc),
        .de_ir    (de_ir),
        .de_valid (de_valid)
    );

endmodule

// File: doc/if_redirect_unit.md
Name: if_redirect_unit

Overview:
- Fetch-side consumer of the hazard unit's control outputs (`pc_sel`, target PCs, `flush`, `load_use_haz`). Owns the PC register, the instruction-memory request handshake and the IF/DE pipeline register.
- Applies redirects and stalls cycle-accurately. Discards in-flight fetches made stale by a redirect.
- Supplies `de_pc`/`de_ir`/`de_valid` to decode.
- Redirect inputs change on negedge CLK; this block samples everything on posedge CLK.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INSTR, 32'h0000_0013, `addi x0,x0,0`, driven on `de_ir` when the slot is invalid.

Ports:
- CLK  in  1  clock, posedge active.
- RST_N  in  1  asynchronous, active-low reset.
- pc_sel  in  2  00 sequential, 01 jalr_pc, 10 branch_pc, 11 jal_pc.
- jalr_pc  in  32  JALR target.
- branch_pc  in  32  taken-branch target.
- jal_pc  in  32  JAL target.
- flush  in  1  kill IF/DE contents (accompanies any nonzero pc_sel).
- load_use_haz  in  1  hold PC and IF/DE this cycle.
- imem_req  out  1  fetch request valid.
- imem_addr  out  32  fetch address, word aligned.
- imem_ready  in  1  memory accepts request when imem_req && imem_ready.
- imem_rvalid  in  1  response valid, 1 cycle pulse, ≥1 cycle after acceptance.
- imem_rdata  in  32  instruction word.
- de_pc  out  32  PC of instruction in IF/DE.
- de_ir  out  32  instruction in IF/DE, NOP_INSTR when invalid.
- de_valid  out  1  IF/DE holds a live instruction.
- misalign_err  out  1  sticky; set when a redirect target has bit1 set.

Behaviour:
- **Reset** (RST_N=0, asynchronous):
  - pc=RESET_PC, state=S_REQ.
  - imem_req=0 during reset; imem_addr=RESET_PC.
  - de_pc=0, de_ir=NOP_INSTR, de_valid=0, misalign_err=0, discard=0.
  - First request is asserted the first cycle after RST_N rises.
- **Outstanding requests:** at most one. No new request is issued until the previous response returns (or is discarded).
- **States:**
  - S_REQ: imem_req=1, imem_addr=pc. On accept → S_WAIT.
  - S_WAIT: imem_req=0. On imem_rvalid:
    - if discard=1: clear discard → S_REQ (response dropped).
    - else if the IF/DE slot can load: load de_ir=imem_rdata, de_pc=pc, de_valid=1, pc<=pc+4 → S_REQ.
    - else: capture into hold buffer → S_HOLD.
  - S_HOLD: buffer valid. When the slot can load: move buffer into IF/DE, pc<=pc+4 → S_REQ.
- **Slot can load** means: load_use_haz=0 and no redirect this cycle.
- **Stall** (load_use_haz=1, no redirect): IF/DE, pc and the buffer all hold. A request already accepted may complete into the buffer.
- **Redirect** (pc_sel≠00, flush=1), highest priority (overrides load_use_haz):
  - target selected by pc_sel; jalr target bit0 cleared; target bit1 sets misalign_err and is forced to 0.
  - de_valid<=0, de_ir<=NOP_INSTR, hold buffer invalidated.
  - pc<=target → S_REQ.
  - If in S_WAIT with no rvalid this cycle: set discard=1, pc<=target, stay in S_WAIT.
  - If rvalid arrives in the same cycle as the redirect: the response is dropped.
  - If in S_REQ and accepted this cycle: discard=1 → S_WAIT.
- **Flush without redirect:** flush=1 with pc_sel=00 clears IF/DE only; pc is unchanged.
- **IF/DE with no new instruction:** when no instruction is loaded and the slot is not stalled, de_valid<=0 and de_ir<=NOP_INSTR (bubble).
- **Width:** pc+4 wraps modulo 2^32 (0xFFFF_FFFC → 0x0000_0000).

Decomposition:
- Shared pipeline package holds:
  - `pc_sel_t` enum: PC_SEQ, PC_JALR, PC_BRANCH, PC_JAL.
  - `fetch_state_t` enum: S_REQ, S_WAIT, S_HOLD.
  - constants NOP_INSTR and RESET_PC.
  - opcode constants shared with the hazard units.
- One sub-module, `if_de_reg`: IF/DE register with load/hold/flush controls and NOP insertion. PC mux and FSM stay in the top module.

Test Plan:
- **Reset then fetch:** reset with zero-latency memory (rvalid the cycle after accept) → fetch addresses 0,4,8; de_valid first high 2 cycles after RST_N rises; de_pc=0.
- **Branch redirect in S_WAIT:** pc_sel=10, branch_pc=0x100, flush=1 while the fetch of 0x8 is outstanding → response for 0x8 dropped; next imem_addr=0x100; de_valid=0 until 0x100's word arrives.
- **Load-use stall:** load_use_haz=1 for 1 cycle with de_pc=0x10 → de_pc/de_ir unchanged that cycle; the next response is held in S_HOLD and enters IF/DE the following cycle; no address is skipped or duplicated.
- **Redirect vs stall:** pc_sel=01, jalr_pc=0x203, load_use_haz=1 simultaneously → redirect wins; imem_addr=0x200 (bit0 cleared), misalign_err=1 (bit1 set, forced to 0), de_valid=0.
- **Wrap and mid-operation reset:** pc=0xFFFF_FFFC → next fetch 0x0. Assert RST_N=0 mid-S_WAIT → outputs immediately at reset values; the stale response after release is not loaded.
